cmd_byte_streamer: RTL and testbench
====================================

CMD_BYTE_STREAMER -- requirements
Module: cmd_byte_streamer

Interface
REQ-001 Parameter: MAX_LEN, default 64, maximum bytes per command string.
REQ-002 Parameter: TIMEOUT_CLKS, default 2000, clocks to wait for tx_done per byte before aborting the command.
REQ-003 Port: clk  input  1  logic clock; all state changes on its rising edge.
REQ-004 Port: rstn  input  1  reset; asynchronous and active-low.
REQ-005 Port: start  input  1  one-cycle request to send the command selected by cmd_sel.
REQ-006 Port: cmd_sel  input  3  command index: 0 empty "\r\n", 1 AT+NAME, 2 AT+ROLE, 3 AT+UART, 4 test text.
REQ-007 Port: abort  input  1  stop after the byte currently in flight.
REQ-008 Port: tx_active  input  1  UART transmitter busy (o_TX_Active).
REQ-009 Port: tx_done  input  1  one-cycle pulse from the UART transmitter when a byte completes.
REQ-010 Port: tx_dv  output  1  one-cycle byte-valid strobe to the UART transmitter.
REQ-011 Port: tx_byte  output  8  byte presented with tx_dv.
REQ-012 Port: busy  output  1  high from accepted start until return to IDLE.
REQ-013 Port: done  output  1  one-cycle pulse when the last byte of a command completes.
REQ-014 Port: err  output  1  sticky error flag: bad cmd_sel or byte timeout; cleared by the next accepted start.

Function
REQ-015 States SHALL be IDLE, LOAD, ISSUE, WAIT_DONE, NEXT, FINISH.
REQ-016 IDLE: start=1 with cmd_sel<=4 SHALL latch cmd_sel, set busy, clear err and go to LOAD on the next edge.
REQ-017 IDLE: start=1 with cmd_sel>4 SHALL set err and stay in IDLE; busy and done stay low.
REQ-018 start while busy=1 SHALL be ignored without error.
REQ-019 LOAD: byte index SHALL reset to 0 and the length SHALL be read from the ROM (lengths 2, 24, 11, 20, 26).
REQ-020 ISSUE: the block SHALL wait for tx_active=0, then assert tx_dv for exactly one cycle with tx_byte=ROM[sel][idx] and go to WAIT_DONE.
REQ-021 tx_byte SHALL hold its value from the tx_dv cycle until the next tx_dv.
REQ-022 WAIT_DONE: on tx_done=1 the block SHALL go to NEXT; the timeout counter SHALL count clocks spent in WAIT_DONE.
REQ-023 A timeout counter reaching TIMEOUT_CLKS SHALL set err and go to IDLE (busy low, no done).
REQ-024 NEXT: if idx==len-1 go to FINISH, else idx+1 and go to ISSUE.
REQ-025 FINISH: done SHALL pulse for one cycle and the block SHALL return to IDLE with busy low on the following cycle.
REQ-026 abort SHALL be sampled in any busy state and held pending; at the next NEXT the block SHALL go to IDLE without done; an in-flight byte is never truncated.
REQ-027 abort in IDLE SHALL have no effect.
REQ-028 Latency: start to first tx_dv SHALL be exactly 2 clocks when tx_active=0.
REQ-029 The index counter SHALL be wide enough for MAX_LEN-1 and SHALL never wrap; lengths above MAX_LEN are a build-time error.
REQ-030 Bytes SHALL go out first-character first; CR is 8'h0D and LF is 8'h0A.

Reset
REQ-031 rstn low SHALL asynchronously force IDLE with tx_dv=0, tx_byte=0, busy=0, done=0 and err=0.
REQ-032 Clearing rstn also clears the index, timeout counter and pending abort.
REQ-033 Reset during a transfer SHALL drop tx_dv immediately; no resume.

Structure
REQ-034 Package hc05_cmd_pkg SHALL hold the state enum, command index constants, the length table and MAX_LEN.
REQ-035 One sub-module, cmd_rom, SHALL map (sel, idx) to a byte combinationally from the package strings.

Verification
REQ-036 Send command 0 with a UART model that returns tx_done 104 clocks after tx_dv -> bytes 0D, 0A; exactly two tx_dv; one done pulse; busy falls 1 clock after done.
REQ-037 Send command 2 -> 11 bytes "AT+ROLE=0" 0D 0A in order; done once; err=0.
REQ-038 start with cmd_sel=6 -> err=1, busy=0, no tx_dv; a later valid start clears err.
REQ-039 Withhold tx_done after byte 3 of command 1 with TIMEOUT_CLKS=2000 -> err=1 and IDLE after 2000 clocks, no done.
REQ-040 Assert abort during byte 5 of command 4 -> byte 5 completes, no 6th tx_dv, no done, busy low.
REQ-041 Pulse rstn low mid-command 3 -> all outputs 0 asynchronously; a new start afterwards sends the full 20 bytes.

Source files
------------

// File: rtl/hc05_cmd_pkg.sv
// Shared definitions for the HC-05 command byte streamer: FSM states,
// command indices, the command string table and its length table.
package hc05_cmd_pkg;

    localparam int MAX_LEN     = 64;
    localparam int NUM_CMDS    = 5;
    localparam int ROM_BYTES   = 26;            // longest command, in bytes
    localparam int ROM_BITS    = ROM_BYTES * 8;
    localparam int ROM_IDX_W   = $clog2(ROM_BYTES);
    localparam int LONGEST_LEN = ROM_BYTES;

    localparam logic [2:0] CMD_EMPTY = 3'd0;
    localparam logic [2:0] CMD_NAME  = 3'd1;
    localparam logic [2:0] CMD_ROLE  = 3'd2;
    localparam logic [2:0] CMD_UART  = 3'd3;
    localparam logic [2:0] CMD_TEXT  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_NEXT      = 3'd4,
        ST_FINISH    = 3'd5
    } state_e;

    // Byte count of each command, CR/LF terminator included.
    function automatic logic [7:0] cmd_len(input logic [2:0] sel);
        case (sel)
            CMD_EMPTY: return 8'd2;
            CMD_NAME:  return 8'd24;
            CMD_ROLE:  return 8'd11;
            CMD_UART:  return 8'd20;
            CMD_TEXT:  return 8'd26;
            default:   return 8'd0;
        endcase
    endfunction

    // Command text, right-justified: the first character sits in the
    // highest occupied byte, the LF terminator in byte 0.
    function automatic logic [ROM_BITS-1:0] cmd_string(input logic [2:0] sel);
        case (sel)
            CMD_EMPTY: return {{24{8'h00}}, 8'h0D, 8'h0A};
            CMD_NAME:  return {{2{8'h00}}, "AT+NAME=HC05_BYTE_LINK", 8'h0D, 8'h0A};
            CMD_ROLE:  return {{15{8'h00}}, "AT+ROLE=0", 8'h0D, 8'h0A};
            CMD_UART:  return {{6{8'h00}}, "AT+UART=115200,0,0", 8'h0D, 8'h0A};
            CMD_TEXT:  return {"HELLO FROM CMD STREAMER!", 8'h0D, 8'h0A};
            default:   return '0;
        endcase
    endfunction

endpackage

// File: rtl/cmd_rom.sv
// Combinational command ROM: returns character idx of command sel,
// first character at idx 0. Out-of-range indices read as 0.
module cmd_rom
    import hc05_cmd_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic [2:0]       sel,
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       data
);

    logic [ROM_BITS-1:0]  str;
    logic [7:0]           bytes [ROM_BYTES];
    logic [15:0]          len16;
    logic [15:0]          idx16;
    logic [ROM_IDX_W-1:0] pos;
    logic                 in_range;

    assign str = cmd_string(sel);

    for (genvar b = 0; b < ROM_BYTES; b++) begin : g_byte
        assign bytes[b] = str[b*8 +: 8];
    end

    // Character idx lives at byte (len-1-idx) of the right-justified string.
    always_comb begin
        len16    = 16'(cmd_len(sel));
        idx16    = 16'(idx);
        in_range = (idx16 < len16);
        pos      = ROM_IDX_W'(len16 - 16'd1 - idx16);
        data     = in_range ? bytes[pos] : 8'h00;
    end

endmodule

// File: rtl/cmd_byte_streamer.sv
// Streams a fixed AT command string, one byte per UART handshake:
// tx_dv out, wait for tx_done back, with per-byte timeout and abort.
module cmd_byte_streamer #(
    parameter int MAX_LEN      = hc05_cmd_pkg::MAX_LEN,
    parameter int TIMEOUT_CLKS = 2000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [2:0] cmd_sel,
    input  logic       abort,
    input  logic       tx_active,
    input  logic       tx_done,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    output logic       busy,
    output logic       done,
    output logic       err
);
    import hc05_cmd_pkg::*;

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LEN_W = IDX_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);

    if (LONGEST_LEN > MAX_LEN) begin : g_len_check
        $error("cmd_byte_streamer: command table longer than MAX_LEN");
    end

    state_e           state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             abort_q, abort_d;
    logic             err_q, err_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [7:0]       rom_byte;
    logic             tx_dv_c;
    logic             is_last;

    cmd_rom #(.IDX_W(IDX_W)) u_rom (
        .sel  (sel_q),
        .idx  (idx_q),
        .data (rom_byte)
    );

    assign is_last = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

    // Next-state logic: byte sequencing, timeout, abort and error tracking.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        len_d     = len_q;
        to_d      = to_q;
        abort_d   = abort_q;
        err_d     = err_q;
        tx_byte_d = tx_byte_q;
        tx_dv_c   = 1'b0;

        if (state_q != ST_IDLE && abort)
            abort_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                to_d    = '0;
                if (start) begin
                    if (cmd_sel <= CMD_TEXT) begin
                        sel_d   = cmd_sel;
                        err_d   = 1'b0;
                        state_d = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                idx_d   = '0;
                len_d   = LEN_W'(cmd_len(sel_q));
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!tx_active) begin
                    tx_dv_c   = 1'b1;
                    tx_byte_d = rom_byte;
                    to_d      = '0;
                    state_d   = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    state_d = ST_NEXT;
                end else if (to_q == TO_W'(TIMEOUT_CLKS - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            ST_NEXT: begin
                // The in-flight byte has completed, so a pending abort
                // can take effect here without truncating anything.
                if (abort_q || abort) begin
                    state_d = ST_IDLE;
                end else if (is_last) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_ISSUE;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            to_q      <= '0;
            abort_q   <= 1'b0;
            err_q     <= 1'b0;
            tx_byte_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            to_q      <= to_d;
            abort_q   <= abort_d;
            err_q     <= err_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    // tx_dv is decoded from state so it meets the two-clock start latency;
    // tx_byte shows the ROM during the strobe and the held copy afterwards.
    assign tx_dv   = tx_dv_c;
    assign tx_byte = tx_dv_c ? rom_byte : tx_byte_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_FINISH);
    assign err     = err_q;

endmodule

// File: tb/tb_cmd_byte_streamer.sv
// Directed bench for cmd_byte_streamer: a UART responder, a queue-based
// model of the expected byte stream and one per-cycle compare process.
module tb_cmd_byte_streamer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic [2:0] cmd_sel = 3'd0;
    logic       abort = 1'b0;
    logic       tx_active = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       busy;
    logic       done;
    logic       err;

    cmd_byte_streamer dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .cmd_sel   (cmd_sel),
        .abort     (abort),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int         nvec = 0;
    int         nerr = 0;
    int         cyc = 0;
    int         dv_cnt = 0;
    int         done_cnt = 0;
    int         last_dv_cyc = 0;
    int         idle_cyc = 0;
    int         lat_start = 0;
    int         lat = -1;
    bit         lat_armed = 0;
    bit         withhold = 0;
    bit         done_prev = 0;
    logic [7:0] last_b = 8'h00;
    logic [7:0] exp_q [$];
    logic [7:0] cap [$];
    int         lens [5] = '{2, 24, 11, 20, 26};

    task automatic chk(input string nm, input int act, input int expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Expected byte stream of a command, built from the command texts.
    function automatic void push_cmd(input int sel);
        string s;
        case (sel)
            1:       s = "AT+NAME=HC05_BYTE_LINK";
            2:       s = "AT+ROLE=0";
            3:       s = "AT+UART=115200,0,0";
            4:       s = "HELLO FROM CMD STREAMER!";
            default: s = "";
        endcase
        for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // UART responder: busy for a byte time, tx_done 104 clocks after tx_dv.
    int  ucnt = 0;
    bit  dv_s;
    always @(posedge clk) begin
        dv_s = tx_dv;
        #1;
        tx_done = 1'b0;
        if (!rstn) begin
            ucnt      = 0;
            tx_active = 1'b0;
        end else if (dv_s) begin
            ucnt      = 103;
            tx_active = 1'b1;
        end else if (ucnt > 0) begin
            ucnt--;
            if (ucnt == 0) begin
                tx_active = 1'b0;
                tx_done   = !withhold;
            end
        end
    end

    // Per-cycle comparison against the expected byte queue.
    always @(negedge clk) begin
        if (!rstn) begin
            last_b    = 8'h00;
            done_prev = 0;
        end else begin
            if (tx_dv) begin
                dv_cnt++;
                last_dv_cyc = cyc;
                cap.push_back(tx_byte);
                if (lat_armed) begin
                    lat       = cyc - lat_start;
                    lat_armed = 0;
                end
                chk("tx_dv_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("tx_byte", int'(tx_byte), int'(exp_q.pop_front()));
                last_b = tx_byte;
            end else begin
                chk("tx_byte_hold", int'(tx_byte), int'(last_b));
            end
            if (done) begin
                done_cnt++;
                chk("done_after_last_byte", exp_q.size(), 0);
                chk("busy_with_done", int'(busy), 1);
            end
            if (done_prev) chk("busy_after_done", int'(busy), 0);
            done_prev = done;
        end
    end

    task automatic send(input int sel, input bit arm);
        @(posedge clk); #1;
        start   = 1'b1;
        cmd_sel = 3'(sel);
        if (arm) begin
            lat_start = cyc;
            lat_armed = 1;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        idle_cyc = cyc;
        chk("idle_within_budget", int'(busy), 0);
    endtask

    task automatic wait_dv(input int target, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (dv_cnt < target && n < budget);
        chk("dv_reached", int'(dv_cnt >= target), 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dv0, dn0;

        // Reset state
        #3;
        chk("rst_tx_dv", int'(tx_dv), 0);
        chk("rst_tx_byte", int'(tx_byte), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Pin the model's command lengths
        for (int k = 0; k < 5; k++) begin
            push_cmd(k);
            chk("model_len", exp_q.size(), lens[k]);
            exp_q.delete();
        end

        // Command 0: CR LF only
        cap.delete(); dv0 = dv_cnt; dn0 = done_cnt;
        push_cmd(0);
        send(0, 1);
        wait_idle(600);
        chk("c0_latency", lat, 2);
        chk("c0_dv_count", dv_cnt - dv0, 2);
        chk("c0_done_count", done_cnt - dn0, 1);
        chk("c0_byte0", int'(cap[0]), 'h0D);
        chk("c0_byte1", int'(cap[1]), 'h0A);
        chk("c0_err", int'(err), 0);

        // Bad selector
        dv0 = dv_cnt;
        send(6, 0);
        @(negedge clk);
        chk("bad_sel_err", int'(err), 1);
        chk("bad_sel_busy", int'(busy), 0);
        repeat (5) @(negedge clk);
        chk("bad_sel_no_dv", dv_cnt - dv0, 0);

        // Abort while idle has no effect
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;

        // Command 2, with a start ignored mid-transfer
        cap.delete(); dv0 = dv_cnt; dn0 = done_cnt;
        push_cmd(2);
        send(2, 1);
        @(negedge clk);
        chk("c2_err_cleared", int'(err), 0);
        repeat (50) @(posedge clk);
        send(7, 0);
        send(1, 0);
        wait_idle(3000);
        chk("c2_dv_count", dv_cnt - dv0, 11);
        chk("c2_done_count", done_cnt - dn0, 1);
        chk("c2_first", int'(cap[0]), 'h41);
        chk("c2_digit", int'(cap[8]), 'h30);
        chk("c2_last", int'(cap[10]), 'h0A);
        chk("c2_err", int'(err), 0);

        // Command 1 with tx_done withheld for byte 3
        dv0 = dv_cnt; dn0 = done_cnt;
        push_cmd(1);
        send(1, 1);
        wait_dv(dv0 + 3, 800);
        withhold = 1;
        wait_idle(3000);
        withhold = 0;
        chk("to_err", int'(err), 1);
        chk("to_dv_count", dv_cnt - dv0, 3);
        chk("to_no_done", done_cnt - dn0, 0);
        chk("to_clocks", idle_cyc - last_dv_cyc, 2001);
        exp_q.delete();

        // Command 4 aborted during byte 5
        dv0 = dv_cnt; dn0 = done_cnt;
        push_cmd(4);
        send(4, 1);
        wait_dv(dv0 + 5, 1000);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_idle(1000);
        repeat (300) @(negedge clk);
        chk("ab_dv_count", dv_cnt - dv0, 5);
        chk("ab_no_done", done_cnt - dn0, 0);
        chk("ab_byte_finished", int'((idle_cyc - last_dv_cyc) >= 104), 1);
        chk("ab_busy", int'(busy), 0);
        chk("ab_err", int'(err), 0);
        exp_q.delete();

        // Reset in the middle of command 3, during a tx_dv cycle
        dv0 = dv_cnt;
        push_cmd(3);
        send(3, 1);
        wait_dv(dv0 + 7, 1500);
        rstn = 1'b0;
        #1;
        chk("mid_rst_tx_dv", int'(tx_dv), 0);
        chk("mid_rst_tx_byte", int'(tx_byte), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_err", int'(err), 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        exp_q.delete();

        // Full command 3 after reset
        cap.delete(); dv0 = dv_cnt; dn0 = done_cnt;
        push_cmd(3);
        send(3, 1);
        wait_idle(4000);
        chk("c3_latency", lat, 2);
        chk("c3_dv_count", dv_cnt - dv0, 20);
        chk("c3_done_count", done_cnt - dn0, 1);
        chk("c3_first", int'(cap[0]), 'h41);
        chk("c3_err", int'(err), 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
